// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor that reuses one 4-bit CLA, one nibble per clock.
// Optional signed-overflow output is enabled by defining CLA_SEQ_ADDER_OVF_EN.

module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] p, g;
    logic [4:0] c;

    assign p    = a_i ^ b_i;
    assign g    = a_i & b_i;
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o  = p ^ c[3:0];
    assign cout_o = c[4];
endmodule

module cla_seq_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
`ifdef CLA_SEQ_ADDER_OVF_EN
   ,output logic                 ovf
`endif
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               sub_q, carry_q, busy_q, done_q;
    logic [IDX_W-1:0]   idx_q;

    logic [3:0]         a_nib, b_nib, cla_sum;
    logic               cla_cout, last_nib;

    // Subtraction is a + ~b + 1; the +1 comes from the carry register loaded at start.
    assign a_nib    = a_q[4*idx_q +: 4];
    assign b_nib    = sub_q ? ~b_q[4*idx_q +: 4] : b_q[4*idx_q +: 4];
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    cla_4bit u_cla (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (cla_sum),
        .cout_o (cla_cout)
    );

`ifdef CLA_SEQ_ADDER_OVF_EN
    logic ovf_q, msb_cin;
    // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
    assign msb_cin = a_nib[3] ^ b_nib[3] ^ cla_sum[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_nib) begin
            ovf_q <= msb_cin ^ cla_cout;
        end
    end

    assign ovf = ovf_q;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[4*idx_q +: 4] <= cla_sum;
                    carry_q             <= cla_cout;
                    if (last_nib) begin
                        state_q <= DONE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = carry_q;
endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
- Nibble-serial multi-word adder/subtractor controller built around one shared cla_4bit instance.
- Sequences WIDTH = 4*NIBBLES bit operands through the 4-bit CLA one nibble per clock, LSB nibble first, with a registered carry between nibbles.
- Provides a start/busy/done handshake to the surrounding datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices. Legal range 1..16. WIDTH = 4*NIBBLES.

Ports:
- clk    input   1        rising-edge clock
- rst    input   1        synchronous active-high reset
- start  input   1        request; sampled only in IDLE
- sub    input   1        1 = a - b, 0 = a + b + cin; latched with start
- cin    input   1        carry-in for add; ignored when sub=1; latched with start
- a      input   WIDTH    operand A; latched with start
- b      input   WIDTH    operand B; latched with start
- busy   output  1        high while in RUN
- done   output  1        one-cycle pulse when result valid
- sum    output  WIDTH    registered result
- cout   output  1        registered final carry; for sub, 1 = no borrow

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the nibble with idx = NIBBLES-1 is processed.
  - DONE -> IDLE unconditionally.
- Start edge (IDLE, start=1):
  - Latch a, b, sub.
  - Load carry register with sub ? 1 : cin.
  - Clear idx to 0.
  - Clear sum to 0.
- Each RUN edge:
  - CLA inputs: a_r[4*idx +: 4], sub ? ~b_r[4*idx +: 4] : b_r[4*idx +: 4], and the carry register.
  - Write the CLA sum to sum[4*idx +: 4].
  - Load the CLA cout into the carry register.
  - Increment idx.
- Latency: with start sampled at edge 0, nibbles are processed at edges 1..NIBBLES. done and busy=0 are visible after edge NIBBLES. done drops after edge NIBBLES+1.
- Handshake rules:
  - busy=1 exactly in RUN.
  - done=1 exactly in DONE.
  - start is ignored in RUN and DONE; no queuing.
  - A new start is accepted at the earliest on the edge after DONE.
- Outputs:
  - sum and cout hold their values from DONE until the next accepted start.
  - cout equals the final carry register value.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Operand inputs may change freely after the start edge; only latched copies are used.
- Reset value: rst=1 at any edge returns to IDLE with busy=0, done=0, sum=0, cout=0, idx=0, carry=0. This applies mid-RUN (operation aborted, no done pulse). rst has priority over start.
- NIBBLES=1: RUN lasts one edge. done is visible after edge 1.
- idx width is clog2(NIBBLES) with a minimum of 1 bit. idx never exceeds NIBBLES-1.

Optional Feature:
- Macro: CLA_SEQ_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered).
  - ovf is two's-complement signed overflow of the full WIDTH operation: carry into the MSB XOR carry out of the MSB, captured on the last RUN edge.
  - Reset to 0.
  - Held with sum.
- Undefined: no ovf port and no related logic. All other behaviour is identical.

Test Plan:
- NIBBLES=4, add, cin=0, a=0x1234, b=0x4321 -> done after edge 4, sum=0x5555, cout=0, busy high for exactly 4 cycles.
- add, cin=0, a=0xFFFF, b=0x0001 -> carry ripples through all nibbles: sum=0x0000, cout=1. With cin=1, a=0x0003, b=0x0007 -> sum=0x000B, cout=0.
- sub=1, cin=1 (ignored), a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Hold start=1 continuously, with operands changed every cycle during RUN:
  - Only one operation runs; the result matches the operands at the start edge.
  - The next operation starts on the edge after DONE.
  - done never lasts more than 1 cycle.
- Assert rst for one cycle at RUN idx=2:
  - Next cycle: IDLE, sum=0, cout=0, busy=0.
  - No done pulse.
  - The following start completes normally.
- CLA_SEQ_ADDER_OVF_EN defined:
  - a=0x7FFF + b=0x0001 -> sum=0x8000, ovf=1.
  - 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1.
  - 0x1234 + 0x4321 -> ovf=0.
- Also run with NIBBLES=1: a=0xF + b=0x1 -> sum=0x0, cout=1, done after edge 1.
